chacha_keystream_gen: RTL and testbench

Parametrised ChaCha block-function engine that produces a burst of consecutive 512-bit keystream blocks from one key/nonce/start-counter command. Round count and the number of parallel quarter-round units are configurable, trading area for throughput. The counter auto-increments per block, and the output uses a valid/ready handshake with backpressure. It sits between key management and the stream XOR datapath, replacing the single-block fixed ChaCha20 core.

---
 rtl/chacha_keystream_gen.sv | 191 +++++++++++++++++++
 tb/tb_chacha_keystream_gen.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/chacha_keystream_gen.sv
// ChaCha block-function engine producing bursts of 512-bit keystream blocks with valid/ready output.
// Optional build macro CHACHA_ZEROIZE_EN clears key material on completion and masks idle output.
module chacha_keystream_gen #(
   parameter int NUM_DOUBLE_ROUNDS = 10,
   parameter int NUM_QR            = 4
) (
   input  logic         i_aclk,
   input  logic         i_aresetn,
   input  logic         i_enable,
   input  logic         i_start,
   input  logic [255:0] i_key,
   input  logic [95:0]  i_nonce,
   input  logic [31:0]  i_counter,
   input  logic [15:0]  i_num_blocks,
   output logic         o_busy,
   output logic [511:0] o_keystream,
   output logic         o_keystream_valid,
   input  logic         i_keystream_ready,
   output logic [31:0]  o_block_counter,
   output logic         o_ctr_wrap,
   output logic         o_done
);

   typedef enum logic [1:0] {IDLE, ROUND, FINAL, HOLD} state_t;

   localparam int         ROUND_EDGES = 8 * NUM_DOUBLE_ROUNDS / NUM_QR;
   localparam logic [7:0] LAST_EDGE   = 8'(ROUND_EDGES - 1);
   localparam logic [2:0] GRP_STEP    = 3'(NUM_QR);

   state_t        state, next_state;
   logic [31:0]   matrix [16];
   logic [31:0]   init [16];
   logic [31:0]   round_matrix [16];
   logic [31:0]   load_state [16];
   logic [7:0]    edge_cnt;
   logic [2:0]    grp;
   logic [15:0]   remaining;
   logic [511:0]  ks_reg, ks_sum;
   logic [15:0]   idx;
   logic [127:0]  res;
   logic          handshake, slot_free, last_block;

   function automatic logic [127:0] quarter_round(input logic [31:0] a_in, b_in, c_in, d_in);
      logic [31:0] a, b, c, d;
      a = a_in; b = b_in; c = c_in; d = d_in;
      a = a + b; d = d ^ a; d = {d[15:0], d[31:16]};
      c = c + d; b = b ^ c; b = {b[19:0], b[31:20]};
      a = a + b; d = d ^ a; d = {d[23:0], d[31:24]};
      c = c + d; b = b ^ c; b = {b[24:0], b[31:25]};
      return {a, b, c, d};
   endfunction

   // Groups 0-3 are the columns, 4-7 the diagonals; the 2-bit adds wrap within each matrix row.
   function automatic logic [15:0] qr_index(input logic [2:0] g);
      logic [1:0] i;
      i = g[1:0];
      if (!g[2]) return {2'b00, i, 2'b01, i, 2'b10, i, 2'b11, i};
      else       return {2'b00, i, 2'b01, i + 2'd1, 2'b10, i + 2'd2, 2'b11, i + 2'd3};
   endfunction

   assign handshake  = o_keystream_valid & i_keystream_ready;
   assign slot_free  = !o_keystream_valid | i_keystream_ready;
   assign last_block = (remaining == 16'd1);

   always_comb begin
      load_state[0] = 32'h61707865;
      load_state[1] = 32'h3320646e;
      load_state[2] = 32'h79622d32;
      load_state[3] = 32'h6b206574;
      for (int k = 0; k < 8; k++) load_state[4 + k] = i_key[32*k +: 32];
      load_state[12] = i_counter;
      for (int k = 0; k < 3; k++) load_state[13 + k] = i_nonce[32*k +: 32];
   end

   // Groups handled in one edge never share a matrix word, so all read the registered matrix.
   always_comb begin
      idx = '0;
      res = '0;
      round_matrix = matrix;
      for (int q = 0; q < NUM_QR; q++) begin
         idx = qr_index(grp + 3'(q));
         res = quarter_round(matrix[idx[15:12]], matrix[idx[11:8]], matrix[idx[7:4]], matrix[idx[3:0]]);
         round_matrix[idx[15:12]] = res[127:96];
         round_matrix[idx[11:8]]  = res[95:64];
         round_matrix[idx[7:4]]   = res[63:32];
         round_matrix[idx[3:0]]   = res[31:0];
      end
   end

   always_comb begin
      ks_sum = '0;
      for (int w = 0; w < 16; w++) ks_sum[32*w +: 32] = matrix[w] + init[w];
   end

   always_ff @(posedge i_aclk or negedge i_aresetn) begin
      if (!i_aresetn)    state <= IDLE;
      else if (i_enable) state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:  if (i_start && i_num_blocks != 16'd0) next_state = ROUND;
         ROUND: if (edge_cnt == LAST_EDGE) next_state = FINAL;
         FINAL: if (slot_free) next_state = last_block ? HOLD : ROUND;
         HOLD:  if (handshake) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge i_aclk or negedge i_aresetn) begin
      if (!i_aresetn) begin
         for (int k = 0; k < 16; k++) begin
            matrix[k] <= '0;
            init[k]   <= '0;
         end
         edge_cnt          <= '0;
         grp               <= '0;
         remaining         <= '0;
         ks_reg            <= '0;
         o_keystream_valid <= 1'b0;
         o_block_counter   <= '0;
         o_busy            <= 1'b0;
         o_done            <= 1'b0;
         o_ctr_wrap        <= 1'b0;
      end else if (i_enable) begin
         o_done     <= 1'b0;
         o_ctr_wrap <= 1'b0;
         if (handshake) o_keystream_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (i_start) begin
                  if (i_num_blocks == 16'd0) begin
                     o_done <= 1'b1;
                  end else begin
                     remaining <= i_num_blocks;
                     o_busy    <= 1'b1;
                     edge_cnt  <= '0;
                     grp       <= '0;
                     for (int k = 0; k < 16; k++) begin
                        matrix[k] <= load_state[k];
                        init[k]   <= load_state[k];
                     end
                  end
               end
            end
            ROUND: begin
               for (int k = 0; k < 16; k++) matrix[k] <= round_matrix[k];
               edge_cnt <= edge_cnt + 8'd1;
               grp      <= grp + GRP_STEP;
            end
            FINAL: begin
               if (slot_free) begin
                  ks_reg            <= ks_sum;
                  o_keystream_valid <= 1'b1;
                  o_block_counter   <= init[12];
                  remaining         <= remaining - 16'd1;
                  if (!last_block) begin
                     init[12]   <= init[12] + 32'd1;
                     o_ctr_wrap <= &init[12];
                     for (int k = 0; k < 16; k++)
                        matrix[k] <= (k == 12) ? init[12] + 32'd1 : init[k];
                     edge_cnt <= '0;
                     grp      <= '0;
                  end
               end
            end
            HOLD: begin
               if (handshake) begin
                  o_done <= 1'b1;
                  o_busy <= 1'b0;
`ifdef CHACHA_ZEROIZE_EN
                  for (int k = 0; k < 16; k++) begin
                     matrix[k] <= '0;
                     init[k]   <= '0;
                  end
`endif
               end
            end
            default: ;
         endcase
      end
   end

`ifdef CHACHA_ZEROIZE_EN
   assign o_keystream = o_keystream_valid ? ks_reg : '0;
`else
   assign o_keystream = ks_reg;
`endif

endmodule

// File: tb/tb_chacha_keystream_gen.sv
// Self-checking bench for chacha_keystream_gen: random key/nonce/counter checked against a
// plain ChaCha20 block model, plus the RFC 8439 vector, backpressure, pause, reset and empty bursts.
module tb_chacha_keystream_gen;

   localparam int QA [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
   localparam int QB [8] = '{4, 5, 6, 7, 5, 6, 7, 4};
   localparam int QC [8] = '{8, 9, 10, 11, 10, 11, 8, 9};
   localparam int QD [8] = '{12, 13, 14, 15, 15, 12, 13, 14};

   logic         aclk, aresetn, enable, start, keystream_ready;
   logic [255:0] key;
   logic [95:0]  nonce;
   logic [31:0]  counter;
   logic [15:0]  num_blocks;
   logic         busy, keystream_valid, ctr_wrap, done;
   logic [511:0] keystream;
   logic [31:0]  block_counter;
   logic         busy_q2, valid_q2, wrap_q2, done_q2;
   logic [511:0] ks_q2;
   logic [31:0]  bc_q2;
   logic         busy_q1, valid_q1, wrap_q1, done_q1;
   logic [511:0] ks_q1;
   logic [31:0]  bc_q1;

   int test_count = 0;
   int fail_count = 0;

   chacha_keystream_gen dut (
      .i_aclk(aclk), .i_aresetn(aresetn), .i_enable(enable), .i_start(start),
      .i_key(key), .i_nonce(nonce), .i_counter(counter), .i_num_blocks(num_blocks),
      .o_busy(busy), .o_keystream(keystream), .o_keystream_valid(keystream_valid),
      .i_keystream_ready(keystream_ready), .o_block_counter(block_counter),
      .o_ctr_wrap(ctr_wrap), .o_done(done)
   );

   chacha_keystream_gen #(.NUM_QR(2)) dut_qr2 (
      .i_aclk(aclk), .i_aresetn(aresetn), .i_enable(enable), .i_start(start),
      .i_key(key), .i_nonce(nonce), .i_counter(counter), .i_num_blocks(num_blocks),
      .o_busy(busy_q2), .o_keystream(ks_q2), .o_keystream_valid(valid_q2),
      .i_keystream_ready(keystream_ready), .o_block_counter(bc_q2),
      .o_ctr_wrap(wrap_q2), .o_done(done_q2)
   );

   chacha_keystream_gen #(.NUM_QR(1)) dut_qr1 (
      .i_aclk(aclk), .i_aresetn(aresetn), .i_enable(enable), .i_start(start),
      .i_key(key), .i_nonce(nonce), .i_counter(counter), .i_num_blocks(num_blocks),
      .o_busy(busy_q1), .o_keystream(ks_q1), .o_keystream_valid(valid_q1),
      .i_keystream_ready(keystream_ready), .o_block_counter(bc_q1),
      .o_ctr_wrap(wrap_q1), .o_done(done_q1)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
      return (v << n) | (v >> (32 - n));
   endfunction

   function automatic logic [511:0] ref_block(input logic [255:0] k, input logic [95:0] n,
                                               input logic [31:0] ctr);
      logic [31:0] s [16];
      logic [31:0] x [16];
      logic [511:0] out;
      int a, b, c, d;
      s[0] = 32'h61707865; s[1] = 32'h3320646e; s[2] = 32'h79622d32; s[3] = 32'h6b206574;
      for (int i = 0; i < 8; i++) s[4 + i] = k[32*i +: 32];
      s[12] = ctr;
      for (int i = 0; i < 3; i++) s[13 + i] = n[32*i +: 32];
      x = s;
      for (int r = 0; r < 10; r++) begin
         for (int g = 0; g < 8; g++) begin
            a = QA[g]; b = QB[g]; c = QC[g]; d = QD[g];
            x[a] = x[a] + x[b]; x[d] = rotl(x[d] ^ x[a], 16);
            x[c] = x[c] + x[d]; x[b] = rotl(x[b] ^ x[c], 12);
            x[a] = x[a] + x[b]; x[d] = rotl(x[d] ^ x[a], 8);
            x[c] = x[c] + x[d]; x[b] = rotl(x[b] ^ x[c], 7);
         end
      end
      for (int w = 0; w < 16; w++) out[32*w +: 32] = x[w] + s[w];
      return out;
   endfunction

   task automatic checkOutput(input string tag, input logic [511:0] got, input logic [511:0] exp);
      test_count++;
      if (got !== exp) begin
         fail_count++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Called one time unit after a rising edge; returns one time unit after the start edge.
   task automatic applyStimulus(input logic [255:0] k, input logic [95:0] n,
                                input logic [31:0] ctr, input logic [15:0] nb);
      key = k; nonce = n; counter = ctr; num_blocks = nb; start = 1'b1;
      @(posedge aclk); #1;
      start = 1'b0;
   endtask

   function automatic logic [255:0] rand_key();
      return {$urandom(), $urandom(), $urandom(), $urandom(),
              $urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   initial begin : main
      logic [255:0] rk, rk2;
      logic [95:0]  rn;
      logic [31:0]  rc;
      logic [511:0] d4, d2, d1, exp1, exp2;
      logic [511:0] blk [3];
      logic [31:0]  bctr [3];
      int           vcyc [3];
      logic [31:0]  bc4;
      int lat4, lat2, lat1, done_cyc, nblk, wraps, seen, bad;

      aresetn = 1'b0; enable = 1'b1; start = 1'b0; keystream_ready = 1'b1;
      key = '0; nonce = '0; counter = '0; num_blocks = '0;
      repeat (3) @(posedge aclk);
      #1;
      checkOutput("reset_keystream", keystream, '0);
      checkOutput("reset_flags", {busy, keystream_valid, ctr_wrap, done}, '0);
      checkOutput("reset_counter", block_counter, '0);
      @(negedge aclk) aresetn = 1'b1;
      @(posedge aclk); #1;

      // RFC 8439 2.3.2 vector on all three quarter-round widths at once
      for (int i = 0; i < 32; i++) rk[8*i +: 8] = 8'(i);
      rn = {32'h00000000, 32'h4a000000, 32'h09000000};
      applyStimulus(rk, rn, 32'd1, 16'd1);
      lat4 = -1; lat2 = -1; lat1 = -1; done_cyc = -1;
      d4 = '0; d2 = '0; d1 = '0; bc4 = '0;
      for (int cyc = 1; cyc <= 120; cyc++) begin
         @(posedge aclk); #1;
         if (lat4 < 0 && keystream_valid) begin lat4 = cyc; d4 = keystream; bc4 = block_counter; end
         if (lat2 < 0 && valid_q2) begin lat2 = cyc; d2 = ks_q2; end
         if (lat1 < 0 && valid_q1) begin lat1 = cyc; d1 = ks_q1; end
         if (done_cyc < 0 && done) done_cyc = cyc;
      end
      exp1 = ref_block(rk, rn, 32'd1);
      checkOutput("rfc_latency_qr4", 512'(lat4), 512'd21);
      checkOutput("rfc_latency_qr2", 512'(lat2), 512'd41);
      checkOutput("rfc_latency_qr1", 512'(lat1), 512'd81);
      checkOutput("rfc_word0", d4[31:0], 32'he4e7f110);
      checkOutput("rfc_word15", d4[511:480], 32'h4e3c50a2);
      checkOutput("rfc_block_model", d4, exp1);
      checkOutput("rfc_block_qr2", d2, exp1);
      checkOutput("rfc_block_qr1", d1, exp1);
      checkOutput("rfc_block_counter", bc4, 32'd1);
      checkOutput("rfc_done_cycle", 512'(done_cyc), 512'd22);

      // Burst of three across the 32-bit counter wrap
      rk = rand_key(); rn = {$urandom(), $urandom(), $urandom()};
      applyStimulus(rk, rn, 32'hFFFFFFFE, 16'd3);
      nblk = 0; wraps = 0; done_cyc = -1;
      for (int i = 0; i < 3; i++) begin blk[i] = '0; bctr[i] = '0; vcyc[i] = -1; end
      for (int cyc = 1; cyc <= 90; cyc++) begin
         @(posedge aclk); #1;
         if (keystream_valid) begin
            if (nblk < 3) begin blk[nblk] = keystream; bctr[nblk] = block_counter; vcyc[nblk] = cyc; end
            nblk++;
         end
         if (ctr_wrap) wraps++;
         if (done_cyc < 0 && done) done_cyc = cyc;
      end
      checkOutput("burst_count", 512'(nblk), 512'd3);
      checkOutput("burst_wraps", 512'(wraps), 512'd1);
      for (int i = 0; i < 3; i++) begin
         rc = 32'hFFFFFFFE + 32'(i);
         checkOutput($sformatf("burst_ctr%0d", i), bctr[i], rc);
         checkOutput($sformatf("burst_blk%0d", i), blk[i], ref_block(rk, rn, rc));
         checkOutput($sformatf("burst_cycle%0d", i), 512'(vcyc[i]), 512'(21 * (i + 1)));
      end
      checkOutput("burst_done_cycle", 512'(done_cyc), 512'd64);

      // Backpressure: block 1 held for 50 cycles, block 2 follows the handshake directly
      rk = rand_key(); rn = {$urandom(), $urandom(), $urandom()}; rc = $urandom();
      exp1 = ref_block(rk, rn, rc);
      exp2 = ref_block(rk, rn, rc + 32'd1);
      keystream_ready = 1'b0;
      applyStimulus(rk, rn, rc, 16'd2);
      seen = 0;
      for (int cyc = 1; cyc <= 60 && seen == 0; cyc++) begin
         @(posedge aclk); #1;
         if (keystream_valid) seen = 1;
      end
      checkOutput("stall_first_valid", 512'(seen), 512'd1);
      bad = 0;
      for (int cyc = 0; cyc < 50; cyc++) begin
         @(posedge aclk); #1;
         if (!keystream_valid || keystream !== exp1 || block_counter !== rc) bad++;
      end
      checkOutput("stall_hold_errors", 512'(bad), 512'd0);
      checkOutput("stall_block1", keystream, exp1);
      keystream_ready = 1'b1;
      @(posedge aclk); #1;
      checkOutput("stall_block2_valid", keystream_valid, 1'b1);
      checkOutput("stall_block2_ctr", block_counter, rc + 32'd1);
      checkOutput("stall_block2_data", keystream, exp2);
      @(posedge aclk); #1;
      checkOutput("stall_done", {keystream_valid, done, busy}, 3'b010);
`ifdef CHACHA_ZEROIZE_EN
      checkOutput("after_last_keystream", keystream, '0);
`else
      checkOutput("after_last_keystream", keystream, exp2);
`endif

      // Asynchronous reset in the middle of the rounds
      applyStimulus(rand_key(), {$urandom(), $urandom(), $urandom()}, $urandom(), 16'd2);
      repeat (5) @(posedge aclk);
      #2 aresetn = 1'b0;
      #1;
      checkOutput("midreset_flags", {busy, keystream_valid, ctr_wrap, done}, '0);
      checkOutput("midreset_keystream", keystream, '0);
      checkOutput("midreset_counter", block_counter, '0);
      @(negedge aclk) aresetn = 1'b1;
      bad = 0;
      for (int cyc = 0; cyc < 30; cyc++) begin
         @(posedge aclk); #1;
         if (done || keystream_valid || busy) bad++;
      end
      checkOutput("midreset_quiet", 512'(bad), 512'd0);

      // Enable pause of 10 cycles, with input changes and a stray start after acceptance
      rk = rand_key(); rn = {$urandom(), $urandom(), $urandom()}; rc = $urandom();
      exp1 = ref_block(rk, rn, rc);
      applyStimulus(rk, rn, rc, 16'd1);
      lat4 = -1; d4 = '0; bc4 = '0;
      for (int cyc = 1; cyc <= 60; cyc++) begin
         @(posedge aclk); #1;
         if (cyc == 3) begin
            rk2 = rand_key();
            key = rk2; counter = $urandom(); nonce = {$urandom(), $urandom(), $urandom()};
            start = 1'b1;
         end
         if (cyc == 4) start = 1'b0;
         if (cyc == 5) enable = 1'b0;
         if (cyc == 10) checkOutput("pause_busy", {busy, keystream_valid}, 2'b10);
         if (cyc == 15) enable = 1'b1;
         if (lat4 < 0 && keystream_valid) begin lat4 = cyc; d4 = keystream; bc4 = block_counter; end
      end
      checkOutput("pause_latency", 512'(lat4), 512'd31);
      checkOutput("pause_block", d4, exp1);
      checkOutput("pause_counter", bc4, rc);

      // Empty burst
      applyStimulus(rand_key(), {$urandom(), $urandom(), $urandom()}, $urandom(), 16'd0);
      checkOutput("empty_done", {done, keystream_valid}, 2'b10);
      bad = 0;
      for (int cyc = 0; cyc < 25; cyc++) begin
         @(posedge aclk); #1;
         if (done || keystream_valid) bad++;
      end
      checkOutput("empty_quiet", 512'(bad), 512'd0);

      $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
      $finish;
   end

endmodule
